// File: rtl/cdi_bus_fabric.sv
// CD-i bus fabric: decodes SCC68070 cycles against programmable regions,
// drives one-hot chip selects and returns a registered ack/error/read path.
module cdi_bus_fabric #(
    parameter int NUM_SLAVES     = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8,
    parameter int IACK_SLAVE     = 1
) (
    input  logic                     clk30,
    input  logic                     reset,
    input  logic                     as,
    input  logic                     uds,
    input  logic                     lds,
    input  logic                     write_strobe,
    input  logic [23:1]              addr,
    input  logic                     iack,
    input  logic [24*NUM_SLAVES-1:0] region_base,
    input  logic [24*NUM_SLAVES-1:0] region_mask,
    input  logic [NUM_SLAVES-1:0]    region_en,
    input  logic [NUM_SLAVES-1:0]    region_byte,
    input  logic [16*NUM_SLAVES-1:0] slave_dout,
    input  logic [NUM_SLAVES-1:0]    slave_ack,
    output logic [NUM_SLAVES-1:0]    cs,
    output logic [15:0]              data_in,
    output logic                     bus_ack,
    output logic                     bus_err,
    output logic [15:0]              err_count,
    output logic [23:0]              err_addr,
    output logic                     err_timeout,
    output logic [1:0]               o_dbg_state
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DECODE   = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_HOLD     = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [23:1]           r_addr;
    logic                  r_uds;
    logic                  r_lds;
    logic                  r_write;
    logic                  r_iack;
    logic [SEL_W-1:0]      r_sel;
    logic                  r_byte;
    logic [TIMEOUT_W-1:0]  r_cnt;
    logic [NUM_SLAVES-1:0] r_cs;
    logic [15:0]           r_data;
    logic                  r_ack;
    logic                  r_err;
    logic [15:0]           r_err_count;
    logic [23:0]           r_err_addr;
    logic                  r_err_to;

    logic [NUM_SLAVES-1:0] w_hit;
    logic                  w_any_hit;
    logic [SEL_W-1:0]      w_hit_idx;
    logic [SEL_W-1:0]      w_dec_sel;
    logic                  w_dec_hit;
    logic                  w_dec_byte;
    logic [NUM_SLAVES-1:0] w_cs_onehot;
    logic                  w_sel_ack;
    logic [15:0]           w_sel_dout;

    logic                  w_latch;
    logic                  w_cs_load;
    logic                  w_cs_drop;
    logic                  w_cnt_inc;
    logic                  w_ack_nxt;
    logic                  w_err_nxt;
    logic                  w_err_to;
    logic                  w_data_load;
    logic [15:0]           w_data_val;

    // Region match on the latched byte address; bit 0 never takes part.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_hit[i] = region_en[i] &&
                ((({r_addr, 1'b0} ^ region_base[24*i +: 24]) &
                  region_mask[24*i +: 24] & 24'hfffffe) == 24'd0);
        end
    end

    always_comb begin
        w_any_hit = |w_hit;
        w_hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (w_hit[i]) w_hit_idx = SEL_W'(i);
        end
    end

    assign w_dec_sel = r_iack ? SEL_W'(IACK_SLAVE) : w_hit_idx;
    assign w_dec_hit = r_iack | w_any_hit;

    always_comb begin
        w_cs_onehot = '0;
        w_dec_byte  = 1'b0;
        w_sel_ack   = 1'b0;
        w_sel_dout  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_dec_sel == SEL_W'(i)) begin
                w_cs_onehot[i] = 1'b1;
                w_dec_byte     = region_byte[i];
            end
            if (r_sel == SEL_W'(i)) begin
                w_sel_ack  = slave_ack[i];
                w_sel_dout = slave_dout[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk30) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Handshake: cs[i] is the request and stays high until the slave raises
    // its level ack (or timeout/abort); the slave holds ack until cs drops.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_cs_load   = 1'b0;
        w_cs_drop   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_err_to    = 1'b0;
        w_data_load = 1'b0;
        w_data_val  = '0;
        case (r_state)
            S_IDLE: begin
                if (as) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!as) begin
                    w_state_nxt = S_IDLE;
                end else if (!r_uds && !r_lds && !r_iack) begin
                    w_ack_nxt   = 1'b1;
                    w_data_load = !r_write;
                    w_state_nxt = S_HOLD;
                end else if (!w_dec_hit) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cs_load   = 1'b1;
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!as) begin
                    w_cs_drop   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_sel_ack) begin
                    w_ack_nxt   = 1'b1;
                    w_data_load = !r_write;
                    w_data_val  = r_byte ? {w_sel_dout[7:0], w_sel_dout[7:0]} : w_sel_dout;
                    w_cs_drop   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (r_cnt == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
                    w_err_nxt   = 1'b1;
                    w_err_to    = 1'b1;
                    w_cs_drop   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            S_HOLD: begin
                if (!as) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk30) begin
        if (reset) begin
            r_addr      <= '0;
            r_uds       <= 1'b0;
            r_lds       <= 1'b0;
            r_write     <= 1'b0;
            r_iack      <= 1'b0;
            r_sel       <= '0;
            r_byte      <= 1'b0;
            r_cnt       <= '0;
            r_cs        <= '0;
            r_data      <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_err_addr  <= '0;
            r_err_to    <= 1'b0;
        end else begin
            r_ack <= w_ack_nxt;
            r_err <= w_err_nxt;
            if (w_latch) begin
                r_addr  <= addr;
                r_uds   <= uds;
                r_lds   <= lds;
                r_write <= write_strobe;
                r_iack  <= iack;
            end
            // Slave choice and its byte-width flag are frozen at decode time.
            if (w_cs_load) begin
                r_cs   <= w_cs_onehot;
                r_sel  <= w_dec_sel;
                r_byte <= w_dec_byte;
                r_cnt  <= '0;
            end else if (w_cs_drop) begin
                r_cs   <= '0;
            end
            if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
            if (w_data_load) r_data <= w_data_val;
            if (w_err_nxt) begin
                if (r_err_count != 16'hffff) r_err_count <= r_err_count + 16'd1;
                r_err_addr <= {r_addr, 1'b0};
                r_err_to   <= w_err_to;
            end
        end
    end

    assign cs          = r_cs;
    assign data_in     = r_data;
    assign bus_ack     = r_ack;
    assign bus_err     = r_err;
    assign err_count   = r_err_count;
    assign err_addr    = r_err_addr;
    assign err_timeout = r_err_to;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cdi_bus_fabric.sv
// Directed bench for cdi_bus_fabric: decode, overlap priority, byte lanes,
// unmapped/timeout errors, abort, iack routing, reset and error-count saturation.
module tb_cdi_bus_fabric;

    localparam int NS = 8;

    logic            clk30;
    logic            reset;
    logic            as;
    logic            uds;
    logic            lds;
    logic            write_strobe;
    logic [23:1]     addr;
    logic            iack;
    logic [24*NS-1:0] region_base;
    logic [24*NS-1:0] region_mask;
    logic [NS-1:0]   region_en;
    logic [NS-1:0]   region_byte;
    logic [16*NS-1:0] slave_dout;
    logic [NS-1:0]   slave_ack;
    logic [NS-1:0]   cs;
    logic [15:0]     data_in;
    logic            bus_ack;
    logic            bus_err;
    logic [15:0]     err_count;
    logic [23:0]     err_addr;
    logic            err_timeout;
    logic [1:0]      o_dbg_state;

    logic [NS-1:0]   ack_en;
    int              n_vec;
    int              n_bad;

    cdi_bus_fabric #(
        .NUM_SLAVES    (NS),
        .TIMEOUT_CYCLES(15),
        .TIMEOUT_W     (8),
        .IACK_SLAVE    (1)
    ) dut (
        .clk30       (clk30),
        .reset       (reset),
        .as          (as),
        .uds         (uds),
        .lds         (lds),
        .write_strobe(write_strobe),
        .addr        (addr),
        .iack        (iack),
        .region_base (region_base),
        .region_mask (region_mask),
        .region_en   (region_en),
        .region_byte (region_byte),
        .slave_dout  (slave_dout),
        .slave_ack   (slave_ack),
        .cs          (cs),
        .data_in     (data_in),
        .bus_ack     (bus_ack),
        .bus_err     (bus_err),
        .err_count   (err_count),
        .err_addr    (err_addr),
        .err_timeout (err_timeout),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk30 = 1'b0;
    always #5 clk30 = ~clk30;

    // Slaves that are enabled to respond ack in the same cycle their cs rises.
    assign slave_ack = cs & ack_en;

    task automatic tick();
        @(posedge clk30);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_regions();
        region_base = '0;
        region_mask = '0;
        region_en   = '0;
        region_byte = '0;
        slave_dout  = '0;
        ack_en      = '0;
    endtask

    task automatic set_region(input int i, input logic [23:0] base,
                              input logic [23:0] mask, input logic byte8);
        region_base[24*i +: 24] = base;
        region_mask[24*i +: 24] = mask;
        region_en[i]            = 1'b1;
        region_byte[i]          = byte8;
    endtask

    task automatic start_access(input logic [23:0] a, input logic u, input logic l,
                                input logic w, input logic k);
        addr         = a[23:1];
        uds          = u;
        lds          = l;
        write_strobe = w;
        iack         = k;
        as           = 1'b1;
    endtask

    task automatic end_access();
        as           = 1'b0;
        uds          = 1'b0;
        lds          = 1'b0;
        write_strobe = 1'b0;
        iack         = 1'b0;
        tick();
    endtask

    task automatic unmapped_access();
        start_access(24'h600000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        end_access();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_vec++; if (cs !== 8'h00)        begin n_bad++; $display("FAIL reset_cs got=%h exp=00", cs); end
        n_vec++; if (data_in !== 16'h0)   begin n_bad++; $display("FAIL reset_data got=%h exp=0000", data_in); end
        n_vec++; if (bus_ack !== 1'b0)    begin n_bad++; $display("FAIL reset_ack got=%b exp=0", bus_ack); end
        n_vec++; if (bus_err !== 1'b0)    begin n_bad++; $display("FAIL reset_err got=%b exp=0", bus_err); end
        n_vec++; if (err_count !== 16'h0) begin n_bad++; $display("FAIL reset_err_count got=%h exp=0000", err_count); end
        n_vec++; if (err_addr !== 24'h0)  begin n_bad++; $display("FAIL reset_err_addr got=%h exp=000000", err_addr); end
        n_vec++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_err_timeout got=%b exp=0", err_timeout); end
        n_vec++; if (o_dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", o_dbg_state); end
    endtask

    task automatic test_hit();
        clear_regions();
        set_region(0, 24'h000000, 24'hC00000, 1'b0);
        slave_dout[15:0] = 16'h1234;
        ack_en = 8'h01;
        start_access(24'h001000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        n_vec++; if (o_dbg_state !== 2'd1) begin n_bad++; $display("FAIL hit_decode_state got=%0d exp=1", o_dbg_state); end
        n_vec++; if (cs !== 8'h00) begin n_bad++; $display("FAIL hit_cs_c1 got=%h exp=00", cs); end
        tick();
        n_vec++; if (cs !== 8'h01) begin n_bad++; $display("FAIL hit_cs_c2 got=%h exp=01", cs); end
        n_vec++; if (bus_ack !== 1'b0) begin n_bad++; $display("FAIL hit_ack_c2 got=%b exp=0", bus_ack); end
        tick();
        n_vec++; if (bus_ack !== 1'b1) begin n_bad++; $display("FAIL hit_ack_c3 got=%b exp=1", bus_ack); end
        n_vec++; if (data_in !== 16'h1234) begin n_bad++; $display("FAIL hit_data got=%h exp=1234", data_in); end
        n_vec++; if (cs !== 8'h00) begin n_bad++; $display("FAIL hit_cs_c3 got=%h exp=00", cs); end
        n_vec++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL hit_no_err got=%b exp=0", bus_err); end
        end_access();
        n_vec++; if (bus_ack !== 1'b0) begin n_bad++; $display("FAIL hit_ack_once got=%b exp=0", bus_ack); end
        n_vec++; if (o_dbg_state !== 2'd0) begin n_bad++; $display("FAIL hit_idle got=%0d exp=0", o_dbg_state); end
    endtask

    task automatic test_overlap_byte();
        clear_regions();
        set_region(2, 24'h300000, 24'hF00000, 1'b1);
        set_region(5, 24'h200000, 24'hE00000, 1'b0);
        slave_dout[16*2 +: 16] = 16'h00AB;
        slave_dout[16*5 +: 16] = 16'h5555;
        ack_en = 8'hFF;
        start_access(24'h300000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        n_vec++; if (cs !== 8'h04) begin n_bad++; $display("FAIL overlap_cs got=%h exp=04", cs); end
        // Region changes after decode must not affect this access.
        region_byte = '0;
        region_en   = '0;
        tick();
        n_vec++; if (bus_ack !== 1'b1) begin n_bad++; $display("FAIL overlap_ack got=%b exp=1", bus_ack); end
        n_vec++; if (data_in !== 16'hABAB) begin n_bad++; $display("FAIL overlap_byte_data got=%h exp=abab", data_in); end
        end_access();
    endtask

    task automatic test_unmapped();
        clear_regions();
        start_access(24'h600000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        n_vec++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL unmap_err got=%b exp=1", bus_err); end
        n_vec++; if (bus_ack !== 1'b0) begin n_bad++; $display("FAIL unmap_ack got=%b exp=0", bus_ack); end
        n_vec++; if (cs !== 8'h00) begin n_bad++; $display("FAIL unmap_cs got=%h exp=00", cs); end
        n_vec++; if (err_count !== 16'd1) begin n_bad++; $display("FAIL unmap_count got=%h exp=0001", err_count); end
        n_vec++; if (err_addr !== 24'h600000) begin n_bad++; $display("FAIL unmap_addr got=%h exp=600000", err_addr); end
        n_vec++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL unmap_to got=%b exp=0", err_timeout); end
        tick();
        n_vec++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL unmap_err_once got=%b exp=0", bus_err); end
        end_access();
    endtask

    task automatic test_timeout();
        int early;
        clear_regions();
        set_region(3, 24'h400000, 24'hE00000, 1'b0);
        start_access(24'h400100, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        n_vec++; if (cs !== 8'h08) begin n_bad++; $display("FAIL to_cs got=%h exp=08", cs); end
        early = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus_err !== 1'b0 || cs !== 8'h08) early++;
        end
        n_vec++; if (early != 0) begin n_bad++; $display("FAIL to_early got=%0d exp=0", early); end
        tick();
        n_vec++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL to_err got=%b exp=1", bus_err); end
        n_vec++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL to_flag got=%b exp=1", err_timeout); end
        n_vec++; if (cs !== 8'h00) begin n_bad++; $display("FAIL to_cs_drop got=%h exp=00", cs); end
        n_vec++; if (err_count !== 16'd2) begin n_bad++; $display("FAIL to_count got=%h exp=0002", err_count); end
        n_vec++; if (err_addr !== 24'h400100) begin n_bad++; $display("FAIL to_addr got=%h exp=400100", err_addr); end
        end_access();
    endtask

    task automatic test_abort();
        int errs;
        clear_regions();
        set_region(3, 24'h400000, 24'hE00000, 1'b0);
        start_access(24'h400200, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        for (int k = 0; k < 5; k++) tick();
        as = 1'b0;
        tick();
        n_vec++; if (cs !== 8'h00) begin n_bad++; $display("FAIL abort_cs got=%h exp=00", cs); end
        n_vec++; if (o_dbg_state !== 2'd0) begin n_bad++; $display("FAIL abort_state got=%0d exp=0", o_dbg_state); end
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus_err !== 1'b0 || bus_ack !== 1'b0) errs++;
        end
        n_vec++; if (errs != 0) begin n_bad++; $display("FAIL abort_pulses got=%0d exp=0", errs); end
        n_vec++; if (err_count !== 16'd2) begin n_bad++; $display("FAIL abort_count got=%h exp=0002", err_count); end
        end_access();
    endtask

    task automatic test_iack();
        clear_regions();
        slave_dout[16*1 +: 16] = 16'h0045;
        ack_en = 8'h02;
        start_access(24'hFFFFFE, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        n_vec++; if (cs !== 8'h02) begin n_bad++; $display("FAIL iack_cs got=%h exp=02", cs); end
        tick();
        n_vec++; if (bus_ack !== 1'b1) begin n_bad++; $display("FAIL iack_ack got=%b exp=1", bus_ack); end
        n_vec++; if (data_in !== 16'h0045) begin n_bad++; $display("FAIL iack_data got=%h exp=0045", data_in); end
        n_vec++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL iack_no_err got=%b exp=0", bus_err); end
        end_access();
    endtask

    task automatic test_write();
        clear_regions();
        set_region(0, 24'h000000, 24'hC00000, 1'b0);
        slave_dout[15:0] = 16'h9999;
        ack_en = 8'h01;
        start_access(24'h000400, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        n_vec++; if (bus_ack !== 1'b1) begin n_bad++; $display("FAIL write_ack got=%b exp=1", bus_ack); end
        n_vec++; if (data_in !== 16'h0045) begin n_bad++; $display("FAIL write_data_kept got=%h exp=0045", data_in); end
        end_access();
    endtask

    task automatic test_no_strobe();
        clear_regions();
        set_region(0, 24'h000000, 24'hC00000, 1'b0);
        slave_dout[15:0] = 16'h7777;
        ack_en = 8'h01;
        start_access(24'h000800, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        n_vec++; if (bus_ack !== 1'b1) begin n_bad++; $display("FAIL nostb_ack got=%b exp=1", bus_ack); end
        n_vec++; if (cs !== 8'h00) begin n_bad++; $display("FAIL nostb_cs got=%h exp=00", cs); end
        n_vec++; if (data_in !== 16'h0000) begin n_bad++; $display("FAIL nostb_data got=%h exp=0000", data_in); end
        end_access();
    endtask

    task automatic test_reset_mid_wait();
        clear_regions();
        set_region(3, 24'h400000, 24'hE00000, 1'b0);
        start_access(24'h400000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_vec++; if (cs !== 8'h00) begin n_bad++; $display("FAIL rst_cs got=%h exp=00", cs); end
        n_vec++; if (o_dbg_state !== 2'd0) begin n_bad++; $display("FAIL rst_state got=%0d exp=0", o_dbg_state); end
        n_vec++; if (data_in !== 16'h0 || err_count !== 16'h0 || err_addr !== 24'h0)
            begin n_bad++; $display("FAIL rst_regs got=%h/%h/%h exp=0/0/0", data_in, err_count, err_addr); end
        n_vec++; if (bus_ack !== 1'b0 || bus_err !== 1'b0 || err_timeout !== 1'b0)
            begin n_bad++; $display("FAIL rst_flags got=%b%b%b exp=000", bus_ack, bus_err, err_timeout); end
        reset = 1'b0;
        end_access();
    endtask

    task automatic test_err_saturation();
        clear_regions();
        for (int k = 0; k < 3; k++) unmapped_access();
        n_vec++; if (err_count !== 16'd3) begin n_bad++; $display("FAIL sat_count3 got=%h exp=0003", err_count); end
        // Preload near the top so saturation is reached in a few accesses.
        force dut.r_err_count = 16'hfffd;
        tick();
        release dut.r_err_count;
        unmapped_access();
        n_vec++; if (err_count !== 16'hfffe) begin n_bad++; $display("FAIL sat_fffe got=%h exp=fffe", err_count); end
        unmapped_access();
        n_vec++; if (err_count !== 16'hffff) begin n_bad++; $display("FAIL sat_ffff got=%h exp=ffff", err_count); end
        unmapped_access();
        unmapped_access();
        n_vec++; if (err_count !== 16'hffff) begin n_bad++; $display("FAIL sat_hold got=%h exp=ffff", err_count); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_vec        = 0;
        n_bad        = 0;
        reset        = 1'b1;
        as           = 1'b0;
        uds          = 1'b0;
        lds          = 1'b0;
        write_strobe = 1'b0;
        addr         = '0;
        iack         = 1'b0;
        clear_regions();
        test_reset();
        test_hit();
        test_overlap_byte();
        test_unmapped();
        test_timeout();
        test_abort();
        test_iack();
        test_write();
        test_no_strobe();
        test_reset_mid_wait();
        test_err_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
